// File: rtl/regfile_mp.sv
// Multi-port general-purpose register file with two write ports, NRD
// combinational read ports, optional write->read bypass, a per-register
// busy scoreboard and a post-reset clear sequencer that gates init_done.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst,
  output logic                init_done,
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [XLEN-1:0]     wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [XLEN-1:0]     wd1,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rbusy,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic [AW-1:0]       dbg_idx,
  output logic [XLEN-1:0]     dbg_data
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [AW:0]   NREG_L   = (AW+1)'(NREG);
  localparam logic [AW-1:0] CNT_LAST = AW'(NREG - 1);
  localparam logic          ZR       = (ZERO_REG != 0);
  localparam logic          BP       = (BYPASS != 0);

  state_t          state, state_nxt;
  logic [AW-1:0]   cnt, cnt_nxt;
  logic [XLEN-1:0] gpr [NREG];
  logic [NREG-1:0] busy;
  logic            run;
  logic            w0_ok, w1_ok, iss_ok;

  // Address names a real, writable register (x0 excluded when hardwired).
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < NREG_L) && !(ZR && (a == '0));
  endfunction

  assign run       = (state == ST_RUN);
  assign init_done = run;

  // Writes and issues only take effect once the clear sequence is over;
  // out-of-range or x0 targets are silently dropped.
  assign w0_ok  = run & we0 & addr_ok(wa0);
  assign w1_ok  = run & we1 & addr_ok(wa1);
  assign iss_ok = run & iss_valid & addr_ok(iss_rd);

  // Clear-sequencer next state: walk cnt across every register, then run.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == ST_INIT) begin
      cnt_nxt = cnt + AW'(1);
      if (cnt == CNT_LAST) state_nxt = ST_RUN;
    end
  end

  // Sequencer state register; reset always restarts the clear from x0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Register array: zeroed one entry per cycle in INIT, written in RUN.
  // Port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      gpr[cnt] <= '0;
    end else begin
      if (w0_ok) gpr[wa0] <= wd0;
      if (w1_ok) gpr[wa1] <= wd1;
    end
  end

  // Busy scoreboard: writeback clears, issue sets; the issue is assigned
  // last so a new producer keeps the register busy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      if (w0_ok)  busy[wa0]    <= 1'b0;
      if (w1_ok)  busy[wa1]    <= 1'b0;
      if (iss_ok) busy[iss_rd] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   a;
    logic            hit0, hit1;
    logic [XLEN-1:0] rd_k;
    logic            rbusy_k;

    assign a    = ra[k*AW +: AW];
    assign hit0 = BP & w0_ok & (wa0 == a);
    assign hit1 = BP & w1_ok & (wa1 == a);

    // Read mux: same-cycle write data (port 1 first) over stored data.
    always_comb begin
      rd_k    = '0;
      rbusy_k = 1'b0;
      if (run && addr_ok(a)) begin
        if (hit1)      rd_k = wd1;
        else if (hit0) rd_k = wd0;
        else           rd_k = gpr[a];
        rbusy_k = busy[a] & ~(hit0 | hit1);
      end
    end

    assign rd[k*XLEN +: XLEN] = rd_k;
    assign rbusy[k]           = rbusy_k;
  end

  assign dbg_data = (run && addr_ok(dbg_idx)) ? gpr[dbg_idx] : '0;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: two instances (default configuration and
// NREG=24 / ZERO_REG=0 / BYPASS=0) share one stimulus stream; a behavioural
// model predicts each cycle's outputs, a monitor compares at the falling edge.
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic        we0, we1, iss_valid;
  logic [4:0]  wa0, wa1, iss_rd, dbg_idx;
  logic [31:0] wd0, wd1;
  logic [9:0]  ra;

  logic        done_a, done_b;
  logic [63:0] rd_a, rd_b;
  logic [1:0]  rb_a, rb_b;
  logic [31:0] dbg_a, dbg_b;

  regfile_mp u_a (
    .clk(clk), .rst(rst), .init_done(done_a),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rd(rd_a), .rbusy(rb_a),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .dbg_idx(dbg_idx), .dbg_data(dbg_a)
  );

  regfile_mp #(.NREG(24), .ZERO_REG(0), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .init_done(done_b),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rd(rd_b), .rbusy(rb_b),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .dbg_idx(dbg_idx), .dbg_data(dbg_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rd_a, rd_b;
    logic [1:0]  rb_a, rb_b;
    logic [31:0] dbg_a, dbg_b;
    logic        done_a, done_b;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: per configuration c (0 = default, 1 = small variant)
  logic [31:0] m_gpr  [2][32];
  bit          m_busy [2][32];
  int          m_left [2];

  function automatic int m_nreg(int c); return (c == 0) ? 32 : 24; endfunction
  function automatic bit m_z(int c);    return (c == 0);           endfunction
  function automatic bit m_byp(int c);  return (c == 0);           endfunction

  function automatic bit m_ok(int c, logic [4:0] a);
    return (int'(a) < m_nreg(c)) && !(m_z(c) && a == 5'd0);
  endfunction

  function automatic bit m_w0v(int c);
    return (m_left[c] == 0) && we0 && m_ok(c, wa0);
  endfunction

  function automatic bit m_w1v(int c);
    return (m_left[c] == 0) && we1 && m_ok(c, wa1);
  endfunction

  function automatic logic [31:0] m_read(int c, logic [4:0] a);
    if (m_left[c] != 0 || !m_ok(c, a)) return 32'h0;
    if (m_byp(c) && m_w1v(c) && wa1 == a) return wd1;
    if (m_byp(c) && m_w0v(c) && wa0 == a) return wd0;
    return m_gpr[c][a];
  endfunction

  function automatic logic m_rbusy(int c, logic [4:0] a);
    bit fwd;
    if (m_left[c] != 0 || !m_ok(c, a)) return 1'b0;
    fwd = m_byp(c) && ((m_w1v(c) && wa1 == a) || (m_w0v(c) && wa0 == a));
    return m_busy[c][a] && !fwd;
  endfunction

  function automatic logic [31:0] m_dbg(int c, logic [4:0] a);
    if (m_left[c] != 0 || !m_ok(c, a)) return 32'h0;
    return m_gpr[c][a];
  endfunction

  // Apply the effect of the coming rising edge to the model.
  task automatic m_commit();
    bit w0v, w1v;
    for (int c = 0; c < 2; c++) begin
      w0v = m_w0v(c);
      w1v = m_w1v(c);
      if (!rst) begin
        m_left[c] = m_nreg(c);
        for (int r = 0; r < 32; r++) begin
          m_gpr[c][r]  = 32'h0;
          m_busy[c][r] = 1'b0;
        end
      end else if (m_left[c] > 0) begin
        m_left[c] = m_left[c] - 1;
      end else begin
        if (w0v) begin m_gpr[c][wa0] = wd0; m_busy[c][wa0] = 1'b0; end
        if (w1v) begin m_gpr[c][wa1] = wd1; m_busy[c][wa1] = 1'b0; end
        if (iss_valid && m_ok(c, iss_rd)) m_busy[c][iss_rd] = 1'b1;
      end
    end
  endtask

  // Inputs are set by the caller; predict this cycle, queue it, advance.
  task automatic step();
    exp_t e;
    e.rd_a   = {m_read(0, ra[9:5]), m_read(0, ra[4:0])};
    e.rd_b   = {m_read(1, ra[9:5]), m_read(1, ra[4:0])};
    e.rb_a   = {m_rbusy(0, ra[9:5]), m_rbusy(0, ra[4:0])};
    e.rb_b   = {m_rbusy(1, ra[9:5]), m_rbusy(1, ra[4:0])};
    e.dbg_a  = m_dbg(0, dbg_idx);
    e.dbg_b  = m_dbg(1, dbg_idx);
    e.done_a = (m_left[0] == 0);
    e.done_b = (m_left[1] == 0);
    q.push_back(e);
    m_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b1; we0 = 1'b0; we1 = 1'b0; iss_valid = 1'b0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; ra = '0; iss_rd = '0; dbg_idx = '0;
  endtask

  function automatic logic [4:0] raddr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare the prediction for this cycle against the DUT outputs.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("done_a", 64'(done_a), 64'(mon_e.done_a));
      chk("done_b", 64'(done_b), 64'(mon_e.done_b));
      chk("rd_a",   rd_a,        mon_e.rd_a);
      chk("rd_b",   rd_b,        mon_e.rd_b);
      chk("rbusy_a", 64'(rb_a),  64'(mon_e.rb_a));
      chk("rbusy_b", 64'(rb_b),  64'(mon_e.rb_b));
      chk("dbg_a",  64'(dbg_a),  64'(mon_e.dbg_a));
      chk("dbg_b",  64'(dbg_b),  64'(mon_e.dbg_b));
    end
  end

  initial begin
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_commit();

    // Reset pulse, then sweep the debug port through INIT and into RUN
    step();
    rst = 1'b1;
    for (int i = 0; i < 64; i++) begin
      dbg_idx = 5'(i);
      step();
    end

    // Single write with bypass, then stored readback
    idle(); we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF; ra = {5'd0, 5'd5};
    step();
    idle(); ra = {5'd0, 5'd5}; dbg_idx = 5'd5;
    step();

    // Same-address collision, x0 write, out-of-range write
    idle(); we0 = 1'b1; we1 = 1'b1; wa0 = 5'd7; wa1 = 5'd7; wd0 = 32'h1; wd1 = 32'h2;
    ra = {5'd7, 5'd7};
    step();
    idle(); ra = {5'd0, 5'd7};
    step();
    idle(); we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF; ra = {5'd0, 5'd0};
    step();
    idle(); we1 = 1'b1; wa1 = 5'd0; wd1 = 32'h1234; ra = {5'd0, 5'd0};
    step();
    idle(); we0 = 1'b1; wa0 = 5'd30; wd0 = 32'hCAFE_F00D; ra = {5'd30, 5'd0}; dbg_idx = 5'd30;
    step();
    idle(); ra = {5'd30, 5'd0}; dbg_idx = 5'd0;
    step();

    // Scoreboard: issue, set-wins-over-clear, later clear by port 1
    idle(); iss_valid = 1'b1; iss_rd = 5'd3; ra = {5'd0, 5'd3};
    step();
    idle(); ra = {5'd0, 5'd3};
    step();
    idle(); iss_valid = 1'b1; iss_rd = 5'd3; we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h33;
    ra = {5'd0, 5'd3};
    step();
    idle(); ra = {5'd0, 5'd3};
    step();
    idle(); we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h44; ra = {5'd3, 5'd3};
    step();
    idle(); ra = {5'd3, 5'd3};
    step();

    // Busy bits set, then reset, then reset again mid-INIT
    idle(); iss_valid = 1'b1; iss_rd = 5'd4;
    step();
    idle(); iss_valid = 1'b1; iss_rd = 5'd3; ra = {5'd4, 5'd3};
    step();
    idle(); rst = 1'b0; ra = {5'd4, 5'd3};
    step();
    idle(); ra = {5'd4, 5'd3};
    repeat (10) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 34; i++) begin
      dbg_idx = 5'(i);
      step();
    end

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) != 0);
      we0       = 1'($urandom_range(0, 1));
      wa0       = raddr();
      wd0       = $urandom();
      we1       = 1'($urandom_range(0, 1));
      wa1       = ($urandom_range(0, 3) == 0) ? wa0 : raddr();
      wd1       = $urandom();
      ra        = {raddr(), raddr()};
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_rd    = raddr();
      dbg_idx   = raddr();
      step();
    end

    idle();
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain actual=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
